// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Each bit lasts 'prescale' clocks; the frame configuration is captured when a byte is accepted.
module uart_tx_core #(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               Data_Valid,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] prescale,
    output logic               TX_OUT,
    output logic               busy,
    output logic               frame_done
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  cyc_cnt_q, cyc_cnt_d;
    logic [PRESC_W-1:0]  p_last_q, p_last_d;
    logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                par_en_q, par_en_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end;

    assign bit_end = (cyc_cnt_q == p_last_q);

    always_comb begin
        state_d   = state_q;
        cyc_cnt_d = cyc_cnt_q;
        p_last_d  = p_last_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (Data_Valid && !busy_q) begin
                    // Everything the frame needs is captured here so the source may change inputs freely.
                    shift_d   = P_DATA;
                    par_d     = (^P_DATA) ^ PAR_TYP;
                    par_en_d  = PAR_EN;
                    p_last_d  = (prescale > PRESC_W'(1)) ? prescale - PRESC_W'(1) : '0;
                    cyc_cnt_d = '0;
                    state_d   = START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PRESC_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    shift_d   = shift_q >> 1;
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        tx_d      = shift_d[0];
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PRESC_W'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    state_d   = STOP;
                    tx_d      = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PRESC_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cyc_cnt_d = '0;
                    state_d   = IDLE;
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + PRESC_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                cyc_cnt_d = '0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cyc_cnt_q <= '0;
            p_last_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            p_last_q  <= p_last_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign TX_OUT     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
